branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Decode-stage branch resolver. Consumes the bypassed ovfl/zero/sign flags from the flag register block and the branch fields of the instruction in ID.
- Evaluates the 3-bit condition code and computes the branch target.
- Issues a registered PC redirect and IF/ID flush pulse.
- Stalls ID while a flag-producing instruction is still too far upstream for its flags to be valid.

Parameters:
- ADDR_W, 16, PC and target width in bits.
- FLUSH_CYCLES, 1, number of cycles flush_if_id stays high after a taken branch (1..3).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- br_valid  input  1  ID holds a branch (B or BR); held stable by the pipeline while stall_id=1
- br_is_reg  input  1  0 = B (PC-relative immediate), 1 = BR (register target)
- cond  input  3  condition code from instruction
- imm9  input  9  signed word offset for B
- reg_target  input  ADDR_W  source register value for BR
- pc_plus2  input  ADDR_W  address of branch instruction + 2
- flags_pending  input  1  flag-setting instruction has not yet reached ALU output; flags not yet valid
- ovfl  input  1  bypassed overflow flag
- zero  input  1  bypassed zero flag
- sign  input  1  bypassed sign flag
- stall_id  output  1  hold PC and IF/ID
- pc_redirect  output  1  one-cycle pulse: load pc_target into PC
- pc_target  output  ADDR_W  redirect address, valid while pc_redirect=1
- flush_if_id  output  1  squash IF/ID contents
- br_taken_cnt  output  16  saturating count of taken branches (debug)

Behaviour:
- Reset (async, rst=1): state=IDLE; stall_id, pc_redirect, flush_if_id = 0; pc_target = 0; br_taken_cnt = 0. Applies immediately, including mid-WAIT or mid-FLUSH.
- Conditions, evaluated on the live ovfl/zero/sign inputs:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: Z=1 | N=1
  - 110 OV: V=1
  - 111 UNCOND: always
- Target:
  - B: pc_plus2 + (sext(imm9) << 1), modulo 2^ADDR_W. Wrap-around is silent.
  - BR: reg_target.
- FSM states: IDLE, WAIT, FLUSH.
- IDLE:
  - br_valid=1 & flags_pending=1 -> WAIT. stall_id=1 combinationally in this same cycle.
  - br_valid=1 & flags_pending=0 -> evaluate now.
    - If taken: register pc_target, pc_redirect=1 and flush_if_id=1 next cycle, go to FLUSH, increment br_taken_cnt.
    - If not taken: stay IDLE, no outputs.
  - br_valid=0 -> stay IDLE.
- WAIT:
  - stall_id=1 while flags_pending=1.
  - In the first cycle flags_pending=0: stall_id=0 and evaluate as in IDLE.
  - Latency from pending drop to redirect is 1 cycle.
  - br_valid dropping in WAIT (external flush) -> IDLE with no redirect.
- FLUSH:
  - pc_redirect is high only in the first FLUSH cycle.
  - flush_if_id stays high for FLUSH_CYCLES cycles, then -> IDLE.
  - br_valid during FLUSH is wrong-path and is ignored.
  - stall_id=0 throughout FLUSH.
- Total latency, taken branch with no pending flags: decision in cycle N, pc_redirect/flush_if_id in N+1.
- Not-taken branch: zero-cycle penalty, no outputs asserted.
- br_taken_cnt saturates at 16'hFFFF. No wrap.
- pc_redirect and stall_id are never high in the same cycle.

Test Plan:
- Reset mid-FLUSH:
  - Stimulus: taken UNCOND B with FLUSH_CYCLES=3; assert rst in the 2nd FLUSH cycle.
  - Required: all outputs 0 asynchronously; state IDLE; br_taken_cnt=0.
- EQ taken, B form:
  - Stimulus: pc_plus2=0x0102, imm9=0x1FE (-2), cond=001, Z=1, pending=0.
  - Required: next cycle pc_redirect=1, pc_target=0x00FE, flush_if_id=1 for 1 cycle; br_taken_cnt=1.
- GT not taken:
  - Stimulus: cond=010, Z=0, N=1.
  - Required: no redirect, no flush, no stall; stays IDLE.
- Pending stall then BR taken:
  - Stimulus: BR, cond=110, flags_pending=1 for 3 cycles, then pending=0 with V=1, reg_target=0xABCE.
  - Required: stall_id=1 for exactly 3 cycles; pc_redirect with pc_target=0xABCE one cycle after pending drops.
- Wrap-around target:
  - Stimulus: pc_plus2=0xFFFE, imm9=0x003, UNCOND.
  - Required: pc_target=0x0004.
- Ignore in FLUSH, counter saturation:
  - Stimulus: FLUSH_CYCLES=2, assert br_valid with UNCOND during FLUSH.
  - Required: no second redirect.
  - Stimulus: preload br_taken_cnt to 0xFFFF, then a taken branch.
  - Required: br_taken_cnt stays 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolver: evaluates the condition code on bypassed flags,
// computes the target, and issues a registered PC redirect plus IF/ID flush.
module branch_resolve_unit #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic              br_is_reg,
  input  logic [2:0]        cond,
  input  logic [8:0]        imm9,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic [ADDR_W-1:0] pc_plus2,
  input  logic              flags_pending,
  input  logic              ovfl,
  input  logic              zero,
  input  logic              sign,
  output logic              stall_id,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_if_id,
  output logic [15:0]       br_taken_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned FC_W  = 2;

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  state_t            r_state;
  logic [FC_W-1:0]   r_flush_cnt;
  logic              r_pc_redirect;
  logic              r_flush_if_id;
  logic [ADDR_W-1:0] r_pc_target;
  logic [CNT_W-1:0]  r_br_taken_cnt;

  logic              w_cond_true;
  logic              w_active;
  logic              w_resolve;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_target;

  // Condition decode on the live (bypassed) flags
  always_comb begin
    w_cond_true = 1'b0;
    case (cond)
      3'b000: w_cond_true = ~zero;
      3'b001: w_cond_true = zero;
      3'b010: w_cond_true = ~zero & ~sign;
      3'b011: w_cond_true = sign;
      3'b100: w_cond_true = zero | (~zero & ~sign);
      3'b101: w_cond_true = zero | sign;
      3'b110: w_cond_true = ovfl;
      3'b111: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Word offset: sign-extended imm9 scaled by 2; target wraps silently
  assign w_offset  = {{(ADDR_W-10){imm9[8]}}, imm9, 1'b0};
  assign w_target  = br_is_reg ? reg_target : (pc_plus2 + w_offset);

  // Branches are only looked at outside FLUSH; FLUSH-cycle branches are wrong-path
  assign w_active  = (r_state != FLUSH);
  assign w_resolve = w_active & br_valid & ~flags_pending & w_cond_true;
  assign stall_id  = w_active & br_valid & flags_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_flush_cnt    <= '0;
      r_pc_redirect  <= 1'b0;
      r_flush_if_id  <= 1'b0;
      r_pc_target    <= '0;
      r_br_taken_cnt <= '0;
    end else begin
      case (r_state)
        IDLE, WAIT: begin
          r_pc_redirect <= 1'b0;
          r_flush_if_id <= 1'b0;
          if (br_valid && flags_pending) begin
            r_state <= WAIT;
          end else if (w_resolve) begin
            r_state       <= FLUSH;
            r_pc_redirect <= 1'b1;
            r_flush_if_id <= 1'b1;
            r_pc_target   <= w_target;
            r_flush_cnt   <= FC_W'(FLUSH_CYCLES - 1);
            if (r_br_taken_cnt != {CNT_W{1'b1}})
              r_br_taken_cnt <= r_br_taken_cnt + CNT_W'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          r_pc_redirect <= 1'b0;
          if (r_flush_cnt == '0) begin
            r_flush_if_id <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - FC_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pc_redirect  = r_pc_redirect;
  assign flush_if_id  = r_flush_if_id;
  assign pc_target    = r_pc_target;
  assign br_taken_cnt = r_br_taken_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: three instances (FLUSH_CYCLES=1,2,3)
// share stimulus; directed scenarios plus randomized traffic against a reference model.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        br_valid;
  logic        br_is_reg;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] reg_target;
  logic [15:0] pc_plus2;
  logic        flags_pending;
  logic        ovfl;
  logic        zero;
  logic        sign;

  logic        o_stall    [3];
  logic        o_redirect [3];
  logic        o_flush    [3];
  logic [15:0] o_target   [3];
  logic [15:0] o_cnt      [3];

  int total;
  int bad;

  branch_resolve_unit #(.ADDR_W(16), .FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_is_reg(br_is_reg), .cond(cond),
    .imm9(imm9), .reg_target(reg_target), .pc_plus2(pc_plus2),
    .flags_pending(flags_pending), .ovfl(ovfl), .zero(zero), .sign(sign),
    .stall_id(o_stall[0]), .pc_redirect(o_redirect[0]), .pc_target(o_target[0]),
    .flush_if_id(o_flush[0]), .br_taken_cnt(o_cnt[0]));

  branch_resolve_unit #(.ADDR_W(16), .FLUSH_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_is_reg(br_is_reg), .cond(cond),
    .imm9(imm9), .reg_target(reg_target), .pc_plus2(pc_plus2),
    .flags_pending(flags_pending), .ovfl(ovfl), .zero(zero), .sign(sign),
    .stall_id(o_stall[1]), .pc_redirect(o_redirect[1]), .pc_target(o_target[1]),
    .flush_if_id(o_flush[1]), .br_taken_cnt(o_cnt[1]));

  branch_resolve_unit #(.ADDR_W(16), .FLUSH_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_is_reg(br_is_reg), .cond(cond),
    .imm9(imm9), .reg_target(reg_target), .pc_plus2(pc_plus2),
    .flags_pending(flags_pending), .ovfl(ovfl), .zero(zero), .sign(sign),
    .stall_id(o_stall[2]), .pc_redirect(o_redirect[2]), .pc_target(o_target[2]),
    .flush_if_id(o_flush[2]), .br_taken_cnt(o_cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rules written straight from the condition table
  function automatic bit ref_taken(input logic [2:0] c, input logic v, input logic z,
                                   input logic n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] ref_target(input logic is_reg, input logic [8:0] imm,
                                             input logic [15:0] rt, input logic [15:0] pc);
    if (is_reg) return rt;
    return 16'(int'(pc) + 2 * int'($signed(imm)));
  endfunction

  // Reference model: cycles of flush remaining per instance, outputs, counter
  int          m_left     [3];
  logic        m_redirect [3];
  logic        m_flush    [3];
  logic [15:0] m_target   [3];
  logic [15:0] m_cnt      [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_left[i]     <= 0;
        m_redirect[i] <= 1'b0;
        m_flush[i]    <= 1'b0;
        m_target[i]   <= 16'h0;
        m_cnt[i]      <= 16'h0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_left[i] > 0) begin
          m_redirect[i] <= 1'b0;
          m_left[i]     <= m_left[i] - 1;
          m_flush[i]    <= (m_left[i] - 1) > 0;
        end else if (br_valid && !flags_pending && ref_taken(cond, ovfl, zero, sign)) begin
          m_redirect[i] <= 1'b1;
          m_flush[i]    <= 1'b1;
          m_left[i]     <= i + 1;
          m_target[i]   <= ref_target(br_is_reg, imm9, reg_target, pc_plus2);
          m_cnt[i]      <= (m_cnt[i] == 16'hFFFF) ? m_cnt[i] : m_cnt[i] + 16'd1;
        end else begin
          m_redirect[i] <= 1'b0;
          m_flush[i]    <= 1'b0;
        end
      end
    end
  end

  task automatic clear_inputs();
    br_valid = 1'b0; br_is_reg = 1'b0; cond = 3'd0; imm9 = 9'd0;
    reg_target = 16'h0; pc_plus2 = 16'h0; flags_pending = 1'b0;
    ovfl = 1'b0; zero = 1'b0; sign = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total += 5;
      if (o_stall[i] !== 1'b0)    begin bad++; $display("FAIL reset_stall[%0d] got %b want 0", i, o_stall[i]); end
      if (o_redirect[i] !== 1'b0) begin bad++; $display("FAIL reset_redirect[%0d] got %b want 0", i, o_redirect[i]); end
      if (o_flush[i] !== 1'b0)    begin bad++; $display("FAIL reset_flush[%0d] got %b want 0", i, o_flush[i]); end
      if (o_target[i] !== 16'h0)  begin bad++; $display("FAIL reset_target[%0d] got %h want 0000", i, o_target[i]); end
      if (o_cnt[i] !== 16'h0)     begin bad++; $display("FAIL reset_cnt[%0d] got %h want 0000", i, o_cnt[i]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    @(negedge clk);
    br_valid = 1'b1; br_is_reg = 1'b0; cond = 3'b111; pc_plus2 = 16'h0200; imm9 = 9'd0;
    @(negedge clk);
    br_valid = 1'b0;
    total++;
    if (o_redirect[2] !== 1'b1) begin bad++; $display("FAIL midflush_redirect got %b want 1", o_redirect[2]); end
    @(negedge clk);
    total += 2;
    if (o_flush[2] !== 1'b1)    begin bad++; $display("FAIL midflush_flush2 got %b want 1", o_flush[2]); end
    if (o_redirect[2] !== 1'b0) begin bad++; $display("FAIL midflush_redirect2 got %b want 0", o_redirect[2]); end
    rst = 1'b1;
    #1;
    total += 5;
    if (o_flush[2] !== 1'b0)    begin bad++; $display("FAIL midflush_rst_flush got %b want 0", o_flush[2]); end
    if (o_redirect[2] !== 1'b0) begin bad++; $display("FAIL midflush_rst_redirect got %b want 0", o_redirect[2]); end
    if (o_target[2] !== 16'h0)  begin bad++; $display("FAIL midflush_rst_target got %h want 0000", o_target[2]); end
    if (o_cnt[2] !== 16'h0)     begin bad++; $display("FAIL midflush_rst_cnt got %h want 0000", o_cnt[2]); end
    if (o_stall[2] !== 1'b0)    begin bad++; $display("FAIL midflush_rst_stall got %b want 0", o_stall[2]); end
    @(negedge clk);
    rst = 1'b0;
    // Back in IDLE: a fresh taken branch must redirect immediately
    br_valid = 1'b1; cond = 3'b111; pc_plus2 = 16'h0300; imm9 = 9'd0;
    @(negedge clk);
    br_valid = 1'b0;
    total += 3;
    if (o_redirect[2] !== 1'b1)  begin bad++; $display("FAIL midflush_idle_redirect got %b want 1", o_redirect[2]); end
    if (o_target[2] !== 16'h0300) begin bad++; $display("FAIL midflush_idle_target got %h want 0300", o_target[2]); end
    if (o_cnt[2] !== 16'h1)      begin bad++; $display("FAIL midflush_idle_cnt got %h want 0001", o_cnt[2]); end
  endtask

  task automatic test_eq_taken();
    do_reset();
    @(negedge clk);
    br_valid = 1'b1; br_is_reg = 1'b0; cond = 3'b001; zero = 1'b1;
    pc_plus2 = 16'h0102; imm9 = 9'h1FE; flags_pending = 1'b0;
    #1;
    total++;
    if (o_stall[0] !== 1'b0) begin bad++; $display("FAIL eq_stall got %b want 0", o_stall[0]); end
    @(negedge clk);
    br_valid = 1'b0;
    total += 4;
    if (o_redirect[0] !== 1'b1)   begin bad++; $display("FAIL eq_redirect got %b want 1", o_redirect[0]); end
    if (o_target[0] !== 16'h00FE) begin bad++; $display("FAIL eq_target got %h want 00fe", o_target[0]); end
    if (o_flush[0] !== 1'b1)      begin bad++; $display("FAIL eq_flush got %b want 1", o_flush[0]); end
    if (o_cnt[0] !== 16'h1)       begin bad++; $display("FAIL eq_cnt got %h want 0001", o_cnt[0]); end
    @(negedge clk);
    total += 2;
    if (o_flush[0] !== 1'b0)    begin bad++; $display("FAIL eq_flush_end got %b want 0", o_flush[0]); end
    if (o_redirect[0] !== 1'b0) begin bad++; $display("FAIL eq_redirect_end got %b want 0", o_redirect[0]); end
  endtask

  task automatic test_gt_not_taken();
    do_reset();
    @(negedge clk);
    br_valid = 1'b1; br_is_reg = 1'b0; cond = 3'b010; zero = 1'b0; sign = 1'b1;
    pc_plus2 = 16'h0400; imm9 = 9'h010;
    #1;
    total++;
    if (o_stall[0] !== 1'b0) begin bad++; $display("FAIL gt_stall got %b want 0", o_stall[0]); end
    @(negedge clk);
    br_valid = 1'b0;
    total += 3;
    if (o_redirect[0] !== 1'b0) begin bad++; $display("FAIL gt_redirect got %b want 0", o_redirect[0]); end
    if (o_flush[0] !== 1'b0)    begin bad++; $display("FAIL gt_flush got %b want 0", o_flush[0]); end
    if (o_cnt[0] !== 16'h0)     begin bad++; $display("FAIL gt_cnt got %h want 0000", o_cnt[0]); end
  endtask

  task automatic test_pending_br();
    do_reset();
    @(negedge clk);
    br_valid = 1'b1; br_is_reg = 1'b1; cond = 3'b110; reg_target = 16'hABCE;
    flags_pending = 1'b1; ovfl = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total += 2;
      if (o_stall[0] !== 1'b1)    begin bad++; $display("FAIL pend_stall[%0d] got %b want 1", k, o_stall[0]); end
      if (o_redirect[0] !== 1'b0) begin bad++; $display("FAIL pend_redirect[%0d] got %b want 0", k, o_redirect[0]); end
      @(negedge clk);
    end
    flags_pending = 1'b0; ovfl = 1'b1;
    #1;
    total++;
    if (o_stall[0] !== 1'b0) begin bad++; $display("FAIL pend_drop_stall got %b want 0", o_stall[0]); end
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    total += 3;
    if (o_redirect[0] !== 1'b1)   begin bad++; $display("FAIL pend_redirect got %b want 1", o_redirect[0]); end
    if (o_target[0] !== 16'hABCE) begin bad++; $display("FAIL pend_target got %h want abce", o_target[0]); end
    if (o_stall[0] !== 1'b0)      begin bad++; $display("FAIL pend_flush_stall got %b want 0", o_stall[0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    br_valid = 1'b1; br_is_reg = 1'b0; cond = 3'b111; pc_plus2 = 16'hFFFE; imm9 = 9'h003;
    @(negedge clk);
    br_valid = 1'b0;
    total += 2;
    if (o_redirect[0] !== 1'b1)   begin bad++; $display("FAIL wrap_redirect got %b want 1", o_redirect[0]); end
    if (o_target[0] !== 16'h0004) begin bad++; $display("FAIL wrap_target got %h want 0004", o_target[0]); end
  endtask

  task automatic test_ignore_in_flush();
    do_reset();
    @(negedge clk);
    br_valid = 1'b1; br_is_reg = 1'b0; cond = 3'b111; pc_plus2 = 16'h1000; imm9 = 9'h010;
    @(negedge clk);
    total += 2;
    if (o_redirect[1] !== 1'b1)   begin bad++; $display("FAIL ign_redirect got %b want 1", o_redirect[1]); end
    if (o_target[1] !== 16'h1020) begin bad++; $display("FAIL ign_target got %h want 1020", o_target[1]); end
    pc_plus2 = 16'h2000;
    #1;
    total++;
    if (o_stall[1] !== 1'b0) begin bad++; $display("FAIL ign_stall got %b want 0", o_stall[1]); end
    @(negedge clk);
    br_valid = 1'b0;
    total += 3;
    if (o_redirect[1] !== 1'b0)   begin bad++; $display("FAIL ign_second_redirect got %b want 0", o_redirect[1]); end
    if (o_flush[1] !== 1'b1)      begin bad++; $display("FAIL ign_flush2 got %b want 1", o_flush[1]); end
    if (o_target[1] !== 16'h1020) begin bad++; $display("FAIL ign_target_hold got %h want 1020", o_target[1]); end
    @(negedge clk);
    total += 3;
    if (o_redirect[1] !== 1'b0) begin bad++; $display("FAIL ign_after_redirect got %b want 0", o_redirect[1]); end
    if (o_flush[1] !== 1'b0)    begin bad++; $display("FAIL ign_after_flush got %b want 0", o_flush[1]); end
    if (o_cnt[1] !== 16'h1)     begin bad++; $display("FAIL ign_cnt got %h want 0001", o_cnt[1]); end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    force u_dut1.r_br_taken_cnt = 16'hFFFF;
    #1 release u_dut1.r_br_taken_cnt;
    @(negedge clk);
    total++;
    if (o_cnt[0] !== 16'hFFFF) begin bad++; $display("FAIL sat_preload got %h want ffff", o_cnt[0]); end
    br_valid = 1'b1; br_is_reg = 1'b1; cond = 3'b111; reg_target = 16'h5550;
    @(negedge clk);
    br_valid = 1'b0;
    total += 2;
    if (o_redirect[0] !== 1'b1) begin bad++; $display("FAIL sat_redirect got %b want 1", o_redirect[0]); end
    if (o_cnt[0] !== 16'hFFFF)  begin bad++; $display("FAIL sat_cnt got %h want ffff", o_cnt[0]); end
  endtask

  task automatic test_random();
    bit hold;
    bit exp_stall;
    hold = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        total += 3;
        if (o_redirect[i] !== m_redirect[i]) begin bad++; $display("FAIL rnd_redirect[%0d] cyc %0d got %b want %b", i, cyc, o_redirect[i], m_redirect[i]); end
        if (o_flush[i] !== m_flush[i])       begin bad++; $display("FAIL rnd_flush[%0d] cyc %0d got %b want %b", i, cyc, o_flush[i], m_flush[i]); end
        if (o_cnt[i] !== m_cnt[i])           begin bad++; $display("FAIL rnd_cnt[%0d] cyc %0d got %h want %h", i, cyc, o_cnt[i], m_cnt[i]); end
        if (m_redirect[i]) begin
          total++;
          if (o_target[i] !== m_target[i]) begin bad++; $display("FAIL rnd_target[%0d] cyc %0d got %h want %h", i, cyc, o_target[i], m_target[i]); end
        end
      end
      // A stalled branch keeps its fields; only pending may change or the branch be squashed
      if (hold && $urandom_range(0, 7) != 0) begin
        flags_pending = 1'($urandom_range(0, 1));
      end else if (hold) begin
        br_valid = 1'b0; flags_pending = 1'b0;
      end else begin
        br_valid      = 1'($urandom_range(0, 1));
        br_is_reg     = 1'($urandom_range(0, 1));
        cond          = 3'($urandom);
        imm9          = 9'($urandom);
        reg_target    = 16'($urandom);
        pc_plus2      = 16'($urandom);
        flags_pending = ($urandom_range(0, 2) == 0);
      end
      {ovfl, zero, sign} = 3'($urandom);
      #1;
      hold = 1'b0;
      for (int i = 0; i < 3; i++) begin
        exp_stall = (m_left[i] == 0) && br_valid && flags_pending;
        total++;
        if (o_stall[i] !== exp_stall) begin bad++; $display("FAIL rnd_stall[%0d] cyc %0d got %b want %b", i, cyc, o_stall[i], exp_stall); end
        if (o_stall[i] === 1'b1 && o_redirect[i] === 1'b1) begin
          bad++; $display("FAIL rnd_stall_and_redirect[%0d] cyc %0d got 1 want 0", i, cyc);
        end
        if (exp_stall) hold = 1'b1;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    clear_inputs();
    test_reset();
    test_eq_taken();
    test_gt_not_taken();
    test_pending_br();
    test_wrap();
    test_ignore_in_flush();
    test_reset_mid_flush();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
